fifo_ctl: RTL and testbench
===========================

Name: fifo_ctl

Overview:
- Parametrised synchronous FIFO. Successor to the fixed 8-bit fifo.
- Generalised in data width and depth.
- Adds: synchronous reset, flush, occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, optional first-word-fall-through mode.
- Sits between byte/word producers and consumers, e.g. serial RX/TX paths and the uFork core's I/O queues, in a single clock domain.

Parameters:
- DATA_SZ, 8, data word width in bits.
- ADDR_SZ, 4, address width; DEPTH = 2**ADDR_SZ entries, all usable.
- AFULL_LVL, DEPTH-2, o_afull asserts when count >= AFULL_LVL.
- AEMPTY_LVL, 1, o_aempty asserts when count <= AEMPTY_LVL.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_flush  in  1  synchronous flush: discard contents; error flags are kept.
- i_wr  in  1  write request.
- i_data  in  DATA_SZ  write data.
- o_full  out  1  no room (count == DEPTH).
- i_rd  in  1  read request.
- o_data  out  DATA_SZ  read data.
- o_empty  out  1  no data available.
- o_count  out  ADDR_SZ+1  current occupancy, 0..DEPTH.
- o_afull  out  1  almost full.
- o_aempty  out  1  almost empty.
- o_ovf  out  1  sticky: write attempted while full.
- o_udf  out  1  sticky: read attempted while empty.

Behaviour:
- Reset values (i_rst high at an edge):
  - Pointers, count and o_data are 0.
  - o_empty=1, o_aempty=1, o_full=0, o_afull=0, o_ovf=0, o_udf=0.
  - Reset has priority over all other inputs. Reset mid-operation discards contents; the storage RAM itself is not cleared.
- Flush: i_flush (without i_rst) has the reset effect on pointers, count and flags except o_ovf and o_udf. o_data holds its value. Flush has priority over i_wr/i_rd in the same cycle.
- Pointers: wr_ptr and rd_ptr are ADDR_SZ+1 bits and increment modulo 2**(ADDR_SZ+1).
  - Storage index is the low ADDR_SZ bits.
  - full when the pointers differ only in the MSB; empty when they are equal.
- Write accepted iff i_wr && !o_full (as seen before the edge). Data is stored at wr_ptr and wr_ptr increments.
- Read accepted iff i_rd && !o_empty (as seen before the edge); rd_ptr increments.
- Simultaneous accepted read and write: count unchanged; both pointers advance.
- When full with i_wr and i_rd both high: the read is accepted and the write is rejected (o_ovf sets). The same cycle's write is not retried.
- When empty with i_wr and i_rd both high: the write is accepted and the read is rejected (o_udf sets).
- Rejected write: data dropped; o_ovf set to 1 on the next edge. Rejected read: o_udf set to 1. Both flags hold until i_rst.
- o_count, o_full, o_empty, o_afull, o_aempty are registered and updated on the same edge that changes the pointers. No combinational path runs from i_wr/i_rd to the status outputs.
- Standard mode: o_data is registered.
  - It is loaded with mem[rd_ptr] on the edge of an accepted read and is valid from the following cycle (latency 1).
  - It holds its value until the next accepted read.
- Write-to-read latency (standard mode): data written at edge N makes o_empty=0 after edge N and can be read at edge N+1.
- Parameter checks (elaboration):
  - AFULL_LVL must satisfy 1 <= AFULL_LVL <= DEPTH.
  - AEMPTY_LVL must satisfy 0 <= AEMPTY_LVL < DEPTH.
  - Violation triggers $error in simulation.

Optional Feature:
- Macro: FIFO_CTL_FWFT_EN.
- Defined: first-word-fall-through.
  - o_data always presents the head entry mem[rd_ptr], read combinationally from storage, whenever o_empty=0.
  - i_rd acknowledges/pops the head.
  - After a pop, the next entry appears in the following cycle with no further latency.
  - o_data is undefined (don't-care) while o_empty=1.
- Undefined: standard registered-read mode as above.
- All flags, count and error behaviour are identical in both modes.

Test Plan:
- Reset with ADDR_SZ=3, DATA_SZ=8; then write 0x40..0x47 on 8 consecutive cycles -> o_count steps 1..8; o_afull asserts at count 6; o_full=1 after 8th write; o_ovf=0.
- From full, write 0x48 -> o_ovf=1 and stays set; o_count=8. Then read 8 times -> o_data sequence 0x40..0x47 (standard: one cycle after each rd; FWFT: before each rd); o_empty=1; 0x48 never appears.
- Empty FIFO with i_rd=1 for 1 cycle -> o_udf=1, o_count=0, o_data unchanged. Then i_rst -> o_udf=0, o_ovf=0.
- Simultaneous i_wr/i_rd at count 4 for 20 cycles with incrementing data -> o_count stays 4; outputs are in order with pointer wrap exercised (>16 pointer increments).
- Write 5 entries, assert i_flush with i_wr=1 in the same cycle -> o_count=0, o_empty=1, write ignored, o_ovf/o_udf unchanged. Next write 0x55, then read -> 0x55.
- Write phase[0] / read phase==2 pacing (4-phase counter) for 200 cycles -> output stream strictly incrementing from 0x40; o_count never exceeds 1 relative to the pacing model; no ovf/udf.

Source files
------------

// File: rtl/fifo_ctl.sv
// fifo_ctl: parametrised single-clock FIFO controller with occupancy count,
// programmable almost-full/almost-empty flags, sticky overflow/underflow
// flags and flush. Define FIFO_CTL_FWFT_EN for first-word-fall-through
// output; otherwise o_data is a registered read with one cycle of latency.
module fifo_ctl #(
  parameter int DATA_SZ    = 8,
  parameter int ADDR_SZ    = 4,
  parameter int AFULL_LVL  = (2 ** ADDR_SZ) - 2,
  parameter int AEMPTY_LVL = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_flush,
  input  logic               i_wr,
  input  logic [DATA_SZ-1:0] i_data,
  output logic               o_full,
  input  logic               i_rd,
  output logic [DATA_SZ-1:0] o_data,
  output logic               o_empty,
  output logic [ADDR_SZ:0]   o_count,
  output logic               o_afull,
  output logic               o_aempty,
  output logic               o_ovf,
  output logic               o_udf
);

  localparam int DEPTH = 2 ** ADDR_SZ;
  localparam logic [ADDR_SZ:0] DEPTH_CNT  = (ADDR_SZ+1)'(DEPTH);
  localparam logic [ADDR_SZ:0] AFULL_CNT  = (ADDR_SZ+1)'(AFULL_LVL);
  localparam logic [ADDR_SZ:0] AEMPTY_CNT = (ADDR_SZ+1)'(AEMPTY_LVL);

  // Threshold sanity checks at elaboration time
  if (AFULL_LVL < 1 || AFULL_LVL > DEPTH) begin : g_afull_chk
    $error("fifo_ctl: AFULL_LVL must be within 1..DEPTH");
  end
  if (AEMPTY_LVL < 0 || AEMPTY_LVL >= DEPTH) begin : g_aempty_chk
    $error("fifo_ctl: AEMPTY_LVL must be within 0..DEPTH-1");
  end

  logic [DATA_SZ-1:0] mem [DEPTH];

  logic [ADDR_SZ:0] wr_ptr_reg, rd_ptr_reg;
  logic [ADDR_SZ:0] wr_ptr_next, rd_ptr_next, count_next;
  logic [ADDR_SZ:0] count_reg;
  logic             full_reg, empty_reg, afull_reg, aempty_reg;
  logic             ovf_reg, udf_reg;
  logic             wr_acc, rd_acc;

  // Accept decisions use the registered flags, so a full FIFO with both
  // requests pops but drops the write, and an empty one pushes but drops
  // the read. Occupancy is the pointer difference (extra MSB disambiguates).
  always_comb begin
    wr_acc      = i_wr && !full_reg;
    rd_acc      = i_rd && !empty_reg;
    wr_ptr_next = wr_ptr_reg + (ADDR_SZ+1)'(wr_acc);
    rd_ptr_next = rd_ptr_reg + (ADDR_SZ+1)'(rd_acc);
    count_next  = wr_ptr_next - rd_ptr_next;
  end

  // Pointers, registered status flags and sticky error flags
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
      afull_reg  <= 1'b0;
      aempty_reg <= 1'b1;
      ovf_reg    <= 1'b0;
      udf_reg    <= 1'b0;
    end else if (i_flush) begin
      // Empty state; error flags survive a flush
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
      afull_reg  <= 1'b0;
      aempty_reg <= 1'b1;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      full_reg   <= (count_next == DEPTH_CNT);
      empty_reg  <= (count_next == '0);
      afull_reg  <= (count_next >= AFULL_CNT);
      aempty_reg <= (count_next <= AEMPTY_CNT);
      if (i_wr && full_reg)
        ovf_reg <= 1'b1;
      if (i_rd && empty_reg)
        udf_reg <= 1'b1;
    end
  end

  // Storage write port; contents are never cleared
  always_ff @(posedge i_clk) begin
    if (!i_rst && !i_flush && wr_acc)
      mem[wr_ptr_reg[ADDR_SZ-1:0]] <= i_data;
  end

`ifdef FIFO_CTL_FWFT_EN
  // Head entry presented directly from storage; meaningless while empty
  assign o_data = mem[rd_ptr_reg[ADDR_SZ-1:0]];
`else
  logic [DATA_SZ-1:0] data_reg;

  // Registered read: loads the head on each accepted pop, holds otherwise
  always_ff @(posedge i_clk) begin
    if (i_rst)
      data_reg <= '0;
    else if (!i_flush && rd_acc)
      data_reg <= mem[rd_ptr_reg[ADDR_SZ-1:0]];
  end

  assign o_data = data_reg;
`endif

  assign o_full   = full_reg;
  assign o_empty  = empty_reg;
  assign o_count  = count_reg;
  assign o_afull  = afull_reg;
  assign o_aempty = aempty_reg;
  assign o_ovf    = ovf_reg;
  assign o_udf    = udf_reg;

endmodule

// File: tb/tb_fifo_ctl.sv
// tb_fifo_ctl: directed scenarios plus randomized traffic for fifo_ctl
// (ADDR_SZ=3, DATA_SZ=8), checked each cycle against a queue-based model.
module tb_fifo_ctl;

  localparam int DATA_SZ = 8;
  localparam int ADDR_SZ = 3;
  localparam int DEPTH   = 2 ** ADDR_SZ;
  localparam int AFULL   = DEPTH - 2;
  localparam int AEMPTY  = 1;

  logic               i_clk = 1'b0;
  logic               i_rst = 1'b0;
  logic               i_flush = 1'b0;
  logic               i_wr = 1'b0;
  logic [DATA_SZ-1:0] i_data = '0;
  logic               i_rd = 1'b0;
  logic               o_full, o_empty, o_afull, o_aempty, o_ovf, o_udf;
  logic [DATA_SZ-1:0] o_data;
  logic [ADDR_SZ:0]   o_count;

  fifo_ctl #(.DATA_SZ(DATA_SZ), .ADDR_SZ(ADDR_SZ)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (i_flush),
    .i_wr    (i_wr),
    .i_data  (i_data),
    .o_full  (o_full),
    .i_rd    (i_rd),
    .o_data  (o_data),
    .o_empty (o_empty),
    .o_count (o_count),
    .o_afull (o_afull),
    .o_aempty(o_aempty),
    .o_ovf   (o_ovf),
    .o_udf   (o_udf)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: contents as a queue, plus error flags and output word
  logic [DATA_SZ-1:0] q[$];
  bit                 m_ovf = 1'b0;
  bit                 m_udf = 1'b0;
  logic [DATA_SZ-1:0] m_dout = '0;

  int errors = 0;
  int checks = 0;
  int txn    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s txn=%0d got=0x%0h expected=0x%0h", tag, txn, obs, exp);
    end
  endtask

  task automatic model(input bit wr, input bit rd, input bit fl, input bit rs,
                       input logic [DATA_SZ-1:0] d);
    int n;
    n = q.size();
    if (rs) begin
      q.delete();
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      m_dout = '0;
    end else if (fl) begin
      q.delete();
    end else begin
      if (wr && n == DEPTH) m_ovf = 1'b1;
      if (rd && n == 0)     m_udf = 1'b1;
      if (rd && n != 0)     m_dout = q.pop_front();
      if (wr && n != DEPTH) q.push_back(d);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("count",  32'(o_count),  32'(n));
    chk("full",   32'(o_full),   32'(n == DEPTH));
    chk("empty",  32'(o_empty),  32'(n == 0));
    chk("afull",  32'(o_afull),  32'(n >= AFULL));
    chk("aempty", 32'(o_aempty), 32'(n <= AEMPTY));
    chk("ovf",    32'(o_ovf),    32'(m_ovf));
    chk("udf",    32'(o_udf),    32'(m_udf));
`ifdef FIFO_CTL_FWFT_EN
    if (n != 0) chk("data", 32'(o_data), 32'(q[0]));
`else
    chk("data", 32'(o_data), 32'(m_dout));
`endif
  endtask

  // One clock cycle: drive, clock, update model, sample 1 time unit later
  task automatic step(input bit wr, input bit rd, input bit fl, input bit rs,
                      input logic [DATA_SZ-1:0] d);
    i_wr = wr; i_rd = rd; i_flush = fl; i_rst = rs; i_data = d;
    @(posedge i_clk);
    model(wr, rd, fl, rs, d);
    #1;
    txn++;
    $display("txn %0d wr=%0b rd=%0b flush=%0b rst=%0b din=%02h -> cnt=%0d dout=%02h ovf=%0b udf=%0b",
             txn, wr, rd, fl, rs, d, o_count, o_data, o_ovf, o_udf);
    check_all();
    i_wr = 1'b0; i_rd = 1'b0; i_flush = 1'b0; i_rst = 1'b0;
  endtask

  initial begin
    logic [DATA_SZ-1:0] val;
    int ph;
    int pw, pr;

    // Reset
    step(0, 0, 0, 1, 8'h00);
    step(0, 0, 0, 1, 8'h00);

    // Fill with 0x40..0x47, then overflow attempt with 0x48
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0, 8'(8'h40 + i));
    step(1, 0, 0, 0, 8'h48);
    step(0, 0, 0, 0, 8'h00);

    // Drain all eight; 0x48 must never appear
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0, 8'h00);

    // Underflow on empty, then reset clears both sticky flags
    step(0, 1, 0, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);
    step(0, 0, 0, 1, 8'h00);

    // Hold occupancy at 4 with simultaneous traffic, wrapping pointers
    val = 8'h10;
    for (int i = 0; i < 4; i++) begin step(1, 0, 0, 0, val); val++; end
    for (int i = 0; i < 20; i++) begin step(1, 1, 0, 0, val); val++; end
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 8'h00);

    // Both requests while full and while empty
    for (int i = 0; i < DEPTH; i++) begin step(1, 0, 0, 0, val); val++; end
    step(1, 1, 0, 0, 8'hEE);
    step(0, 0, 0, 1, 8'h00);
    step(1, 1, 0, 0, 8'h77);
    step(0, 1, 0, 0, 8'h00);

    // Flush with a concurrent write; error flags survive
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 8'(8'h20 + i));
    step(1, 0, 1, 0, 8'hAA);
    step(1, 0, 0, 0, 8'h55);
    step(0, 1, 0, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);

    // Four-phase paced stream: write on phase 0, read on phase 2
    step(0, 0, 0, 1, 8'h00);
    val = 8'h40;
    ph = 0;
    for (int i = 0; i < 200; i++) begin
      if (ph == 0) begin step(1, 0, 0, 0, val); val++; end
      else if (ph == 2) step(0, 1, 0, 0, 8'h00);
      else step(0, 0, 0, 0, 8'h00);
      chk("pace_cnt", 32'(o_count <= 1), 32'd1);
      ph = (ph + 1) % 4;
    end

    // Randomized traffic, alternately write-heavy and read-heavy
    for (int i = 0; i < 400; i++) begin
      pw = ((i / 50) % 2 == 0) ? 70 : 35;
      pr = ((i / 50) % 2 == 0) ? 35 : 70;
      step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
           $urandom_range(0, 99) < 2, $urandom_range(0, 199) == 0,
           8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
